// File: rtl/vec_mul_pkg.sv
// Shared types and step-count helpers for the byte-serial vector multiplier.
package vec_mul_pkg;

  typedef enum logic [1:0] {PREC_8, PREC_16, PREC_32, PREC_RSVD} prec_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Number of 8x8 partial products: lanes * k * k.
  function automatic logic [4:0] num_steps(prec_e p);
    case (p)
      PREC_8:  return 5'd4;
      PREC_16: return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [2:0] bytes_per_lane(prec_e p);
    case (p)
      PREC_8:  return 3'd1;
      PREC_16: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/multiplier_8bit.sv
// Combinational unsigned 8x8 multiplier core shared by the sequencer.
module multiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);
  assign product = {8'd0, a} * {8'd0, b};
endmodule

// File: rtl/vec_mul_sequencer.sv
// 32-bit vector multiplier: 4x8 / 2x16 / 1x32 lanes, one byte partial product
// per cycle through a single 8x8 core, shift-accumulated into a 64-bit result.
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int VEC_WIDTH   = 32,
  parameter bit ERR_ON_RSVD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [1:0]  precision,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        err,
  output logic [1:0]  dbg_state
);

  if (VEC_WIDTH != 32) begin : g_width_check
    $error("vec_mul_sequencer supports VEC_WIDTH=32 only");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid/result/err hold in DONE until out_ready.

  state_e      state, state_d;
  prec_e       prec_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc;
  logic [3:0]  cnt;
  logic        err_q;

  logic        rsvd_req, rsvd_err;
  prec_e       prec_eff;
  logic [1:0]  a_sel, b_sel;
  logic [5:0]  shamt;
  logic [15:0] pp;
  logic        last_step;

  assign rsvd_req = (prec_e'(precision) == PREC_RSVD);
  assign rsvd_err = rsvd_req && ERR_ON_RSVD;
  assign prec_eff = rsvd_req ? PREC_32 : prec_e'(precision);
  assign last_step = ({1'b0, cnt} == (num_steps(prec_q) - 5'd1));

  // Step decode: lane = cnt/(k*k), i = idx%k picks the a byte, j = idx/k the b byte.
  always_comb begin
    a_sel = cnt[1:0];
    b_sel = cnt[1:0];
    shamt = {cnt[1:0], 4'd0};
    case (prec_q)
      PREC_8: begin
        a_sel = cnt[1:0];
        b_sel = cnt[1:0];
        shamt = {cnt[1:0], 4'd0};
      end
      PREC_16: begin
        a_sel = {cnt[2], cnt[0]};
        b_sel = {cnt[2], cnt[1]};
        shamt = {cnt[2], 5'd0} + {2'd0, cnt[0], 3'd0} + {2'd0, cnt[1], 3'd0};
      end
      default: begin
        a_sel = cnt[1:0];
        b_sel = cnt[3:2];
        shamt = {1'b0, cnt[1:0], 3'd0} + {1'b0, cnt[3:2], 3'd0};
      end
    endcase
  end

  multiplier_8bit u_mul (
    .a       (a_q[8*a_sel +: 8]),
    .b       (b_q[8*b_sel +: 8]),
    .product (pp)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = rsvd_err ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prec_q <= PREC_8;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= operand_a;
          b_q    <= operand_b;
          prec_q <= prec_eff;
          err_q  <= rsvd_err;
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc <= acc + ({48'd0, pp} << shamt);
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = out_valid ? acc : 64'd0;
  assign err       = out_valid && err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Directed + randomized bench for vec_mul_sequencer; dut 0 rejects reserved
// precision, dut 1 treats it as 32-bit.
module tb_vec_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[2];
  logic        ordy[2];
  logic        irdy[2];
  logic        ov[2];
  logic [63:0] res[2];
  logic        er[2];
  logic [1:0]  dbg[2];
  logic [31:0] operand_a, operand_b;
  logic [1:0]  precision;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_mul_sequencer #(.VEC_WIDTH(32), .ERR_ON_RSVD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .operand_a(operand_a), .operand_b(operand_b), .precision(precision),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .err(er[0]),
    .dbg_state(dbg[0])
  );

  vec_mul_sequencer #(.VEC_WIDTH(32), .ERR_ON_RSVD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .operand_a(operand_a), .operand_b(operand_b), .precision(precision),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .err(er[1]),
    .dbg_state(dbg[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each lane's unsigned product placed at result[2W*L +: 2W].
  function automatic logic [63:0] model(input logic [1:0] p, input logic [31:0] a,
                                        input logic [31:0] b, input bit err_on);
    logic [63:0] r = 64'd0;
    logic [63:0] av, bv, mask;
    int w;
    if (p == 2'b11 && err_on) return 64'd0;
    w = (p == 2'b00) ? 8 : (p == 2'b01) ? 16 : 32;
    mask = (64'd1 << w) - 64'd1;
    for (int l = 0; l < 32 / w; l++) begin
      av = ({32'd0, a} >> (w * l)) & mask;
      bv = ({32'd0, b} >> (w * l)) & mask;
      r = r | ((av * bv) << (2 * w * l));
    end
    return r;
  endfunction

  // Edges after the accepting edge until out_valid is seen; a rejected reserved
  // request is already in DONE in the cycle right after acceptance.
  function automatic int model_lat(input logic [1:0] p, input bit err_on);
    if (p == 2'b11 && err_on) return 0;
    return (p == 2'b00) ? 4 : (p == 2'b01) ? 8 : 16;
  endfunction

  task automatic run_op(input int d, input logic [1:0] p, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp_q[$];
    logic [63:0] exp_r, held;
    int lat, exp_lat, guard;
    bit err_on;
    err_on = (d == 0);
    exp_q.push_back(model(p, a, b, err_on));
    exp_lat = model_lat(p, err_on);
    guard = 0;
    while (!irdy[d] && guard < 50) begin tick(); guard++; end
    check("ready_before_accept", {63'd0, irdy[d]}, 64'd1);
    operand_a = a; operand_b = b; precision = p; iv[d] = 1'b1;
    tick();
    iv[d] = 1'b0;
    operand_a = 'x; operand_b = 'x; precision = $urandom_range(0, 3);
    lat = 0;
    while (!ov[d] && lat < 40) begin
      check("in_ready_low_busy", {63'd0, irdy[d]}, 64'd0);
      check("result_zero_busy", res[d], 64'd0);
      tick(); lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    exp_r = exp_q.pop_front();
    check("result", res[d], exp_r);
    check("err", {63'd0, er[d]}, {63'd0, (p == 2'b11 && err_on)});
    held = res[d];
    for (int c = 0; c < hold; c++) begin
      operand_a = $urandom; operand_b = $urandom; precision = 2'b00;
      iv[d] = 1'b1;
      tick();
      check("hold_valid", {63'd0, ov[d]}, 64'd1);
      check("hold_result", res[d], held);
      check("hold_no_accept", {63'd0, irdy[d]}, 64'd0);
    end
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    iv[d] = 1'b0;
    check("drain_valid_low", {63'd0, ov[d]}, 64'd0);
    check("drain_idle", {63'd0, irdy[d]}, 64'd1);
    check("drain_result_zero", res[d], 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b0; ordy[1] = 1'b0;
    operand_a = '0; operand_b = '0; precision = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", {63'd0, irdy[0]}, 64'd1);
    check("rst_out_valid", {63'd0, ov[0]}, 64'd0);
    check("rst_result", res[0], 64'd0);
    check("rst_err", {63'd0, er[0]}, 64'd0);

    check("vec1_model", model(2'b00, 32'hFF02_0310, 32'hFF05_0410, 1), 64'hFE01_000A_000C_0100);
    run_op(0, 2'b00, 32'hFF02_0310, 32'hFF05_0410, 0);
    run_op(0, 2'b01, 32'hFFFF_1234, 32'hFFFF_5678, 0);
    run_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, 2'b00, 32'h1122_3344, 32'h5566_7788, 5);
    run_op(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1, 2'b10, 32'h8000_0001, 32'hDEAD_BEEF, 0);

    // Reset in the middle of a 32-bit operation.
    operand_a = 32'hFFFF_FFFF; operand_b = 32'h1234_5678; precision = 2'b10; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", {63'd0, irdy[0]}, 64'd1);
    check("midrst_valid", {63'd0, ov[0]}, 64'd0);
    check("midrst_result", res[0], 64'd0);
    run_op(0, 2'b00, 32'h0A0B_0C0D, 32'hF0E0_D0C0, 0);

    for (int n = 0; n < 24; n++) begin
      run_op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
